// File: rtl/crop_cap_pkg.sv
// rtl/crop_cap_pkg.sv - shared constants, luma helper and FSM states for the crop luma capture
package crop_cap_pkg;
   localparam int CROP_W          = 224;
   localparam int CROP_H          = 224;
   localparam int WORDS_PER_FRAME = CROP_W * CROP_H / 4;

   localparam logic [15:0] COEF_R = 16'd77;
   localparam logic [15:0] COEF_G = 16'd150;
   localparam logic [15:0] COEF_B = 16'd29;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Coefficients sum to 256, so the 16-bit sum never wraps and [15:8] is the luma.
   function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
      logic [15:0] sum;
      sum = COEF_R * {8'd0, r} + COEF_G * {8'd0, g} + COEF_B * {8'd0, b};
      return sum[15:8];
   endfunction
endpackage

// File: rtl/cap_fifo.sv
// rtl/cap_fifo.sv - first-word-fall-through FIFO carrying {addr, data} words to the write port
module cap_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      // A pop in the same cycle frees the slot, so a push against a full FIFO still lands.
      do_push  = push && (!full || do_pop);
      drop     = push && !do_push;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/crop_luma_capture.sv
// rtl/crop_luma_capture.sv - one-frame crop-window luma capture, packed 4 bytes/word to a write port
module crop_luma_capture #(
   parameter int CROP_W     = crop_cap_pkg::CROP_W,
   parameter int CROP_H     = crop_cap_pkg::CROP_H,
   parameter int PIX_DLY    = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              VS,
   input  logic              DE,
   input  logic              ACTIV_C,
   input  logic [7:0]        R,
   input  logic [7:0]        G,
   input  logic [7:0]        B,
   input  logic              ARM,
   output logic              BUSY,
   output logic              DONE,
   input  logic              DONE_ACK,
   output logic              ERR_SHORT,
   output logic              OVERFLOW,
   output logic              WR_VALID,
   input  logic              WR_READY,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [31:0]       WR_DATA
);
   import crop_cap_pkg::*;

   localparam int NPIX = CROP_W * CROP_H;
   localparam int PW   = $clog2(NPIX + 1);
   localparam int FW   = ADDR_W + 32;

   state_t            state_q, state_d;
   logic              vs_q, vs_d;
   logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [23:0]       samp_q, samp_d;
   logic              samp_vld_q, samp_vld_d;
   logic [7:0]        luma_q, luma_d;
   logic              luma_vld_q, luma_vld_d;
   logic [23:0]       pack_q, pack_d;
   logic [1:0]        lane_q, lane_d;
   logic              err_short_q, err_short_d;
   logic              overflow_q, overflow_d;

   logic [23:0]       rgb_dly;
   logic              vs_rise, take, push, full, empty, drop;
   logic [FW-1:0]     push_data, pop_data;

   generate
      if (PIX_DLY == 0) begin : g_nodly
         assign rgb_dly = {R, G, B};
      end else begin : g_dly
         logic [23:0] pipe_q [PIX_DLY];
         always_ff @(posedge CLK) begin
            pipe_q[0] <= {R, G, B};
            for (int i = 1; i < PIX_DLY; i++) pipe_q[i] <= pipe_q[i-1];
         end
         assign rgb_dly = pipe_q[PIX_DLY-1];
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      vs_d        = VS;
      pix_cnt_d   = pix_cnt_q;
      addr_d      = addr_q;
      pack_d      = pack_q;
      lane_d      = lane_q;
      err_short_d = err_short_q;
      overflow_d  = overflow_q | drop;

      vs_rise    = VS && !vs_q;
      take       = (state_q == ST_CAPTURE) && DE && ACTIV_C && (pix_cnt_q < PW'(NPIX));
      samp_d     = rgb_dly;
      samp_vld_d = take;
      luma_d     = luma8(samp_q[23:16], samp_q[15:8], samp_q[7:0]);
      luma_vld_d = samp_vld_q;

      // The fourth luma goes straight into the push word; the first three wait in pack_q.
      push      = luma_vld_q && (lane_q == 2'd3);
      push_data = {addr_q, luma_q, pack_q};

      if (luma_vld_q) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    pack_d[7:0]   = luma_q;
            2'd1:    pack_d[15:8]  = luma_q;
            2'd2:    pack_d[23:16] = luma_q;
            default: ;
         endcase
      end
      if (push) addr_d = addr_q + ADDR_W'(1);
      if (take) pix_cnt_d = pix_cnt_q + PW'(1);

      case (state_q)
         ST_IDLE: begin
            if (ARM) begin
               state_d     = ST_WAIT_VS;
               pix_cnt_d   = '0;
               addr_d      = '0;
               pack_d      = '0;
               lane_d      = '0;
               err_short_d = 1'b0;
               overflow_d  = 1'b0;
            end
         end
         ST_WAIT_VS: if (vs_rise) state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            if (take && (pix_cnt_q == PW'(NPIX - 1))) begin
               state_d = ST_DRAIN;
            end else if (vs_rise) begin
               err_short_d = 1'b1;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: if (!samp_vld_q && !luma_vld_q && empty) state_d = ST_DONE;
         ST_DONE:  if (DONE_ACK) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         vs_q        <= 1'b0;
         pix_cnt_q   <= '0;
         addr_q      <= '0;
         samp_q      <= '0;
         samp_vld_q  <= 1'b0;
         luma_q      <= '0;
         luma_vld_q  <= 1'b0;
         pack_q      <= '0;
         lane_q      <= '0;
         err_short_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs_d;
         pix_cnt_q   <= pix_cnt_d;
         addr_q      <= addr_d;
         samp_q      <= samp_d;
         samp_vld_q  <= samp_vld_d;
         luma_q      <= luma_d;
         luma_vld_q  <= luma_vld_d;
         pack_q      <= pack_d;
         lane_q      <= lane_d;
         err_short_q <= err_short_d;
         overflow_q  <= overflow_d;
      end
   end

   cap_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (CLK),
      .reset     (RESET),
      .push      (push),
      .push_data (push_data),
      .pop       (WR_READY),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty),
      .drop      (drop)
   );

   assign BUSY      = (state_q != ST_IDLE);
   assign DONE      = (state_q == ST_DONE);
   assign ERR_SHORT = err_short_q;
   assign OVERFLOW  = overflow_q;
   assign WR_VALID  = !empty;
   assign WR_ADDR   = empty ? '0 : pop_data[FW-1:32];
   assign WR_DATA   = empty ? '0 : pop_data[31:0];
endmodule
